counter_game_sequencer: RTL and testbench
=========================================

// Module: counter_game_sequencer
// PURPOSE
//  - Controller for the multi-mode counter game. Accepts a game request from the host over a valid/ready handshake.
//  - Initialises the counter (INIT + loadValue), then steps its 2-bit ctrl through a 4-slot mode schedule.
//  - Tallies WINNER/LOSER pulses and detects GAMEOVER, then returns the result over a valid/ready handshake.
//  - Sits between the host/testbench stimulus layer and the counter instance on Counter_Interface.
// PARAMETERS
//  - COUNTER_SIZE  4     width of load value (matches counter)
//  - DWELL_W       8     width of per-slot dwell count
//  - CYC_W         16    width of game cycle counter
//  - MAX_CYCLES    4000  watchdog limit; used only with GAME_TIMEOUT_EN
// PORTS
//  - clk             in   1             single clock, all logic posedge
//  - rst_l           in   1             synchronous reset, active-low
//  - start_valid     in   1             host requests a game
//  - start_ready     out  1             sequencer can accept (IDLE only)
//  - load_value      in   COUNTER_SIZE  counter start value
//  - mode_seq        in   8             4 ctrl codes; slot k = [2k+1:2k]
//  - dwell           in   DWELL_W       cycles per slot (0 treated as 1)
//  - abort           in   1             host abort request
//  - cnt_init        out  1             to counter INIT
//  - cnt_load_value  out  COUNTER_SIZE  to counter loadValue
//  - cnt_ctrl        out  2             to counter ctrl
//  - cnt_winner      in   1             from counter WINNER
//  - cnt_loser       in   1             from counter LOSER
//  - cnt_gameover    in   1             from counter GAMEOVER
//  - cnt_who         in   2             from counter WHO
//  - done_valid      out  1             result available
//  - done_ready      in   1             host consumes result
//  - result_who      out  2             01 loser, 10 winner, 11 aborted/timeout
//  - result_cycles   out  CYC_W         RUN cycles elapsed, saturating
//  - win_events      out  4             WINNER pulses seen, saturate at 15
//  - lose_events     out  4             LOSER pulses seen, saturate at 15
//  - busy            out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rst_l=0 at posedge):
//    - state=IDLE; all outputs 0, including start_ready.
//    - start_ready=1 from the first cycle after reset release.
//  - FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE. All outputs registered.
//  - IDLE:
//    - start_ready=1. On start_valid&&start_ready, latch load_value/mode_seq/dwell; clear counters and result.
//    - Go to LOAD.
//  - LOAD:
//    - Exactly one cycle with cnt_init=1 and cnt_load_value=latched value, then RUN.
//    - Latency: accept at edge N -> cnt_init high in cycle N+1 -> RUN with cnt_ctrl=slot0 in cycle N+2.
//  - RUN:
//    - cnt_ctrl=mode_seq[slot]. Slot advances after max(dwell,1) cycles; slot wraps 3->0.
//    - result_cycles increments each RUN cycle and saturates at all-ones.
//    - Each sampled cnt_winner/cnt_loser high increments its event counter (saturating).
//    - cnt_gameover sampled high -> latch result_who=cnt_who, go to DONE.
//  - DONE:
//    - done_valid=1; result_who, result_cycles and event counters held stable.
//    - cnt_ctrl=00. On done_ready, go to IDLE.
//  - abort in LOAD or RUN -> DONE with result_who=11. abort in IDLE/DONE is ignored.
//  - Simultaneous cnt_gameover and abort: gameover wins, result_who=cnt_who.
//  - Counter flags are ignored outside RUN. start_valid is ignored while busy (start_ready=0).
//  - cnt_ctrl=00 and cnt_init=0 in every state except RUN and LOAD respectively.
//  - Reset mid-game: immediate return to IDLE; any pending done_valid is dropped.
// CONFIGURATION
//  - GAME_TIMEOUT_EN defined:
//    - result_cycles reaching MAX_CYCLES in RUN -> DONE, result_who=11.
//    - An extra registered output timeout (1 bit) is set in DONE and cleared on the next start accept.
//  - Not defined: no watchdog and no timeout port; a game ends only on gameover or abort.
// STRUCTURE
//  - Package counter_game_pkg:
//    - ctrl_e {UP_ONE=00, UP_TWO=01, DOWN_ONE=10, DOWN_TWO=11}
//    - who_e {WHO_NONE=00, WHO_LOSER=01, WHO_WINNER=10, WHO_ABORT=11}
//    - seq_state_e {IDLE, LOAD, RUN, DONE}
//  - Sub-module mode_slot_timer: dwell down-counter plus 2-bit slot pointer.
//    - Inputs: clear, enable, dwell. Outputs: slot.
// TESTING
//  - Reset: rst_l=0 for 2 cycles -> all outputs 0; start_ready=1 one cycle after release.
//  - Start: load_value=5, mode_seq=8'h00, dwell=3 -> cnt_init pulse of 1 cycle with cnt_load_value=5; cnt_ctrl=00 in RUN.
//  - Schedule: mode_seq=8'hE4, dwell=2 -> cnt_ctrl sequence 00,00,01,01,10,10,11,11,00...
//  - Gameover: drive cnt_winner 3 times, then cnt_gameover with cnt_who=10 -> done_valid next cycle.
//    - Expect result_who=10, win_events=3. Holding done_ready=0 for 5 cycles keeps the outputs stable.
//  - Abort: abort together with cnt_gameover (cnt_who=01) -> result_who=01. Abort alone in RUN -> result_who=11.
//  - Timeout (GAME_TIMEOUT_EN, MAX_CYCLES=20): no gameover -> DONE after 20 RUN cycles, result_who=11, timeout=1.

Source files
------------

// File: rtl/counter_game_pkg.sv
// Shared types and helpers for the multi-mode counter game sequencer.
package counter_game_pkg;

    typedef enum logic [1:0] {
        UP_ONE   = 2'b00,
        UP_TWO   = 2'b01,
        DOWN_ONE = 2'b10,
        DOWN_TWO = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10,
        WHO_ABORT  = 2'b11
    } who_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_e;

    localparam int unsigned EVT_W = 4;

    function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] v);
        return (v == '1) ? v : v + EVT_W'(1);
    endfunction

endpackage

// File: rtl/mode_slot_timer.sv
// Dwell down-counter and 2-bit slot pointer stepping the mode schedule.
module mode_slot_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         slot
);

    logic [DWELL_W-1:0] remain_q, remain_d, reload;
    logic [1:0]         slot_q, slot_d;

    always_comb begin
        // A dwell of 0 behaves like 1: advance every cycle.
        reload   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        remain_d = remain_q;
        slot_d   = slot_q;
        if (clear) begin
            remain_d = reload;
            slot_d   = 2'd0;
        end else if (enable) begin
            if (remain_q == '0) begin
                remain_d = reload;
                slot_d   = slot_q + 2'd1;
            end else begin
                remain_d = remain_q - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            remain_q <= '0;
            slot_q   <= 2'd0;
        end else begin
            remain_q <= remain_d;
            slot_q   <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/counter_game_sequencer.sv
// Game controller: accepts a request, loads the counter, steps its mode schedule, reports result.
// Optional watchdog enabled by defining GAME_TIMEOUT_EN (adds the timeout output).
module counter_game_sequencer
    import counter_game_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE = 4,
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned CYC_W        = 16
`ifdef GAME_TIMEOUT_EN
    ,
    parameter int unsigned MAX_CYCLES   = 4000
`endif
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [COUNTER_SIZE-1:0] load_value,
    input  logic [7:0]              mode_seq,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic                    abort,
    output logic                    cnt_init,
    output logic [COUNTER_SIZE-1:0] cnt_load_value,
    output logic [1:0]              cnt_ctrl,
    input  logic                    cnt_winner,
    input  logic                    cnt_loser,
    input  logic                    cnt_gameover,
    input  logic [1:0]              cnt_who,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [1:0]              result_who,
    output logic [CYC_W-1:0]        result_cycles,
    output logic [EVT_W-1:0]        win_events,
    output logic [EVT_W-1:0]        lose_events,
`ifdef GAME_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic                    busy
);

    seq_state_e              state_q, state_d;
    logic [COUNTER_SIZE-1:0] load_q, load_d;
    logic [7:0]              mode_q, mode_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [CYC_W-1:0]        cycles_q, cycles_d;
    logic [EVT_W-1:0]        win_q, win_d, lose_q, lose_d;
    logic [1:0]              who_q, who_d;
    logic                    start_ready_q, busy_q, cnt_init_q, done_valid_q;
    logic [1:0]              slot;
`ifdef GAME_TIMEOUT_EN
    logic                    timeout_q, timeout_d;
`endif

    mode_slot_timer #(
        .DWELL_W(DWELL_W)
    ) u_slot_timer (
        .clk   (clk),
        .rst_l (rst_l),
        .clear (state_q != RUN),
        .enable(state_q == RUN),
        .dwell (dwell_q),
        .slot  (slot)
    );

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        mode_d   = mode_q;
        dwell_d  = dwell_q;
        cycles_d = cycles_q;
        win_d    = win_q;
        lose_d   = lose_q;
        who_d    = who_q;
`ifdef GAME_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    load_d   = load_value;
                    mode_d   = mode_seq;
                    dwell_d  = dwell;
                    cycles_d = '0;
                    win_d    = '0;
                    lose_d   = '0;
                    who_d    = WHO_NONE;
`ifdef GAME_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    who_d   = WHO_ABORT;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
                if (cnt_winner) win_d = sat_inc_evt(win_q);
                if (cnt_loser)  lose_d = sat_inc_evt(lose_q);
                // Gameover takes priority over a simultaneous abort.
                if (cnt_gameover) begin
                    who_d   = cnt_who;
                    state_d = DONE;
                end else if (abort) begin
                    who_d   = WHO_ABORT;
                    state_d = DONE;
                end
`ifdef GAME_TIMEOUT_EN
                else if (cycles_d >= CYC_W'(MAX_CYCLES)) begin
                    who_d     = WHO_ABORT;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            load_q        <= '0;
            mode_q        <= '0;
            dwell_q       <= '0;
            cycles_q      <= '0;
            win_q         <= '0;
            lose_q        <= '0;
            who_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_init_q    <= 1'b0;
            done_valid_q  <= 1'b0;
`ifdef GAME_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            mode_q        <= mode_d;
            dwell_q       <= dwell_d;
            cycles_q      <= cycles_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            who_q         <= who_d;
            start_ready_q <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            cnt_init_q    <= (state_d == LOAD);
            done_valid_q  <= (state_d == DONE);
`ifdef GAME_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Built only from registered state, slot and schedule; no input-to-output path.
    always_comb begin
        cnt_ctrl = UP_ONE;
        if (state_q == RUN) begin
            unique case (slot)
                2'd0: cnt_ctrl = mode_q[1:0];
                2'd1: cnt_ctrl = mode_q[3:2];
                2'd2: cnt_ctrl = mode_q[5:4];
                2'd3: cnt_ctrl = mode_q[7:6];
                default: cnt_ctrl = UP_ONE;
            endcase
        end
    end

    assign start_ready    = start_ready_q;
    assign busy           = busy_q;
    assign cnt_init       = cnt_init_q;
    assign cnt_load_value = load_q;
    assign done_valid     = done_valid_q;
    assign result_who     = who_q;
    assign result_cycles  = cycles_q;
    assign win_events     = win_q;
    assign lose_events    = lose_q;
`ifdef GAME_TIMEOUT_EN
    assign timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_counter_game_sequencer.sv
// Directed bench for counter_game_sequencer; timeout case runs when GAME_TIMEOUT_EN is defined.
module tb_counter_game_sequencer;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  load_value;
    logic [7:0]  mode_seq;
    logic [7:0]  dwell;
    logic        abort;
    logic        cnt_init;
    logic [3:0]  cnt_load_value;
    logic [1:0]  cnt_ctrl;
    logic        cnt_winner;
    logic        cnt_loser;
    logic        cnt_gameover;
    logic [1:0]  cnt_who;
    logic        done_valid;
    logic        done_ready;
    logic [1:0]  result_who;
    logic [15:0] result_cycles;
    logic [3:0]  win_events;
    logic [3:0]  lose_events;
    logic        busy;
`ifdef GAME_TIMEOUT_EN
    logic        timeout;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_game_sequencer #(
        .COUNTER_SIZE(4),
        .DWELL_W     (8),
        .CYC_W       (16)
`ifdef GAME_TIMEOUT_EN
        ,
        .MAX_CYCLES  (20)
`endif
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .load_value    (load_value),
        .mode_seq      (mode_seq),
        .dwell         (dwell),
        .abort         (abort),
        .cnt_init      (cnt_init),
        .cnt_load_value(cnt_load_value),
        .cnt_ctrl      (cnt_ctrl),
        .cnt_winner    (cnt_winner),
        .cnt_loser     (cnt_loser),
        .cnt_gameover  (cnt_gameover),
        .cnt_who       (cnt_who),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .result_who    (result_who),
        .result_cycles (result_cycles),
        .win_events    (win_events),
        .lose_events   (lose_events),
`ifdef GAME_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .busy          (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the DUT in its LOAD cycle.
    task automatic start_game(input logic [3:0] lv, input logic [7:0] ms, input logic [7:0] dw);
        load_value  = lv;
        mode_seq    = ms;
        dwell       = dw;
        start_valid = 1'b1;
        tick(1);
        start_valid = 1'b0;
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        tick(1);
        done_ready = 1'b0;
    endtask

    logic [1:0] sched_exp [9];

    initial begin
        sched_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        rst_l = 1'b0; start_valid = 1'b0; load_value = '0; mode_seq = '0; dwell = '0;
        abort = 1'b0; cnt_winner = 1'b0; cnt_loser = 1'b0; cnt_gameover = 1'b0;
        cnt_who = '0; done_ready = 1'b0;

        // Reset
        tick(2);
        chk("rst_start_ready", start_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_cnt_init", cnt_init, 0);
        chk("rst_cnt_ctrl", cnt_ctrl, 0);
        chk("rst_result", {result_who, result_cycles, win_events, lose_events}, 0);
        rst_l = 1'b1;
        tick(1);
        chk("post_rst_start_ready", start_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_ready", start_ready, 1);

        // Start: one-cycle init with load value, then RUN with slot0
        start_game(4'd5, 8'h00, 8'd3);
        chk("load_init", cnt_init, 1);
        chk("load_value", cnt_load_value, 5);
        chk("load_ready", start_ready, 0);
        chk("load_busy", busy, 1);
        tick(1);
        chk("run_init_low", cnt_init, 0);
        chk("run_ctrl", cnt_ctrl, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_run_valid", done_valid, 1);
        chk("abort_run_who", result_who, 3);
        chk("abort_run_cycles", result_cycles, 1);
        finish_done();
        chk("done_to_idle_valid", done_valid, 0);
        chk("done_to_idle_ready", start_ready, 1);

        // Schedule E4, dwell 2; start_valid while busy is ignored
        start_game(4'd2, 8'hE4, 8'd2);
        chk("sched_load_ctrl", cnt_ctrl, 0);
        start_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk($sformatf("sched_ctrl_%0d", i), cnt_ctrl, sched_exp[i]);
        end
        chk("busy_ready_low", start_ready, 0);
        start_valid = 1'b0;
        abort = 1'b1;
        tick(1);
        chk("sched_abort_who", result_who, 3);
        chk("sched_abort_cycles", result_cycles, 9);
        chk("done_ctrl_zero", cnt_ctrl, 0);
        // abort still high in DONE: ignored
        tick(1);
        abort = 1'b0;
        chk("done_abort_ignored", {done_valid, result_who}, 3'b111);
        finish_done();

        // Gameover after 3 winner pulses; winner during LOAD is not counted
        start_game(4'd7, 8'h00, 8'd1);
        cnt_winner = 1'b1;
        tick(2);
        cnt_loser = 1'b1;
        tick(1);
        cnt_loser = 1'b0;
        tick(1);
        cnt_winner = 1'b0;
        cnt_gameover = 1'b1;
        cnt_who = 2'b10;
        tick(1);
        cnt_gameover = 1'b0;
        cnt_who = 2'b00;
        chk("go_valid", done_valid, 1);
        chk("go_who", result_who, 2);
        chk("go_win", win_events, 3);
        chk("go_lose", lose_events, 1);
        chk("go_cycles", result_cycles, 4);
        // Flags outside RUN are ignored; outputs hold while done_ready low
        cnt_winner = 1'b1;
        cnt_gameover = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk($sformatf("go_hold_%0d", i),
                {done_valid, result_who, win_events, result_cycles}, {1'b1, 2'd2, 4'd3, 16'd4});
        end
        cnt_winner = 1'b0;
        cnt_gameover = 1'b0;
        finish_done();

        // Gameover and abort together: gameover wins; counters cleared by new start
        start_game(4'd1, 8'h00, 8'd1);
        tick(1);
        abort = 1'b1;
        cnt_gameover = 1'b1;
        cnt_who = 2'b01;
        tick(1);
        abort = 1'b0;
        cnt_gameover = 1'b0;
        cnt_who = 2'b00;
        chk("both_who", result_who, 1);
        chk("both_win_cleared", win_events, 0);
        chk("both_cycles", result_cycles, 1);
        finish_done();

        // Winner event counter saturates at 15
        start_game(4'd3, 8'h00, 8'd1);
        tick(1);
        cnt_winner = 1'b1;
        tick(17);
        cnt_winner = 1'b0;
        cnt_gameover = 1'b1;
        cnt_who = 2'b10;
        tick(1);
        cnt_gameover = 1'b0;
        chk("sat_win", win_events, 15);
        chk("sat_cycles", result_cycles, 18);
        finish_done();

        // Abort in LOAD
        start_game(4'd4, 8'h00, 8'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("load_abort", {done_valid, result_who, result_cycles}, {1'b1, 2'd3, 16'd0});

        // Reset while DONE drops done_valid
        rst_l = 1'b0;
        tick(1);
        chk("rst_done_valid_drop", done_valid, 0);
        chk("rst_done_who", result_who, 0);
        rst_l = 1'b1;
        tick(1);

        // Reset mid-RUN
        start_game(4'd9, 8'hFF, 8'd1);
        tick(1);
        chk("mid_run_ctrl", cnt_ctrl, 3);
        rst_l = 1'b0;
        tick(1);
        chk("mid_rst", {busy, start_ready, cnt_ctrl}, 0);
        rst_l = 1'b1;
        tick(1);
        chk("mid_rst_release", start_ready, 1);

`ifdef GAME_TIMEOUT_EN
        // Watchdog: no gameover, DONE after 20 RUN cycles
        start_game(4'd6, 8'h00, 8'd1);
        tick(1);
        tick(19);
        chk("to_not_yet", done_valid, 0);
        tick(1);
        chk("to_valid", done_valid, 1);
        chk("to_who", result_who, 3);
        chk("to_flag", timeout, 1);
        chk("to_cycles", result_cycles, 20);
        finish_done();
        start_game(4'd6, 8'h00, 8'd1);
        chk("to_cleared", timeout, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        finish_done();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
